l1_miss_arbiter: RTL

L1_MISS_ARBITER -- requirements
Module: l1_miss_arbiter

---
 rtl/l1_cache_pkg.sv | 17 +
 rtl/l1_miss_arbiter_if.sv | 63 ++++++
 rtl/l1_rr_arbiter.sv | 27 ++
 rtl/l1_miss_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// Shared sizing constants and FSM encoding for the L1 refill/writeback arbiter.
package l1_cache_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int BLK_WORDS = 8;
    localparam int IDX_W     = $clog2(BLK_WORDS);
    localparam int BLK_W     = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/l1_miss_arbiter_if.sv
// Bundle of the I-cache, D-cache and next-level memory signals seen by the
// miss arbiter. master = arbiter side, slave = caches + memory side.
interface l1_miss_arbiter_if #(
    parameter int ADDR_W    = l1_cache_pkg::ADDR_W,
    parameter int DATA_W    = l1_cache_pkg::DATA_W,
    parameter int BLK_WORDS = l1_cache_pkg::BLK_WORDS
);
    localparam int IDX_W = $clog2(BLK_WORDS);
    localparam int BLK_W = ADDR_W - IDX_W;

    // I-cache
    logic              i_miss;
    logic [BLK_W-1:0]  i_addr;
    logic              i_fill_valid;
    logic [IDX_W-1:0]  i_fill_idx;
    logic [DATA_W-1:0] i_fill_data;
    logic              i_done;

    // D-cache
    logic              d_miss;
    logic [BLK_W-1:0]  d_addr;
    logic [BLK_W-1:0]  d_victim_addr;
    logic              d_dirty;
    logic [IDX_W-1:0]  d_wb_idx;
    logic [DATA_W-1:0] d_wb_data;
    logic              d_fill_valid;
    logic [IDX_W-1:0]  d_fill_idx;
    logic [DATA_W-1:0] d_fill_data;
    logic              d_done;

    // Next-level memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              owner_d;

    modport master (
        input  i_miss, i_addr,
        input  d_miss, d_addr, d_victim_addr, d_dirty, d_wb_data,
        input  mem_ack, mem_rdata,
        output i_fill_valid, i_fill_idx, i_fill_data, i_done,
        output d_wb_idx, d_fill_valid, d_fill_idx, d_fill_data, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, owner_d
    );

    modport slave (
        output i_miss, i_addr,
        output d_miss, d_addr, d_victim_addr, d_dirty, d_wb_data,
        output mem_ack, mem_rdata,
        input  i_fill_valid, i_fill_idx, i_fill_data, i_done,
        input  d_wb_idx, d_fill_valid, d_fill_idx, d_fill_data, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, owner_d
    );

endinterface

// File: rtl/l1_rr_arbiter.sv
// Two-way round-robin grant between the I and D refill requesters.
// Remembers who was served last; a tie goes to the other one.
module l1_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic update,     // a transaction is retiring this cycle
    input  logic served_d,   // owner of the retiring transaction
    output logic grant_d     // 1 = D wins, 0 = I wins (when any request)
);

    logic last_d_q;

    // Last-served tracker, starts as "I served last" so D wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (update) begin
            last_d_q <= served_d;
        end
    end

    // D wins when I is not asking, or when I was the one served last.
    assign grant_d = req_d & (~req_i | ~last_d_q);

endmodule

// File: rtl/l1_miss_arbiter.sv
// Serialises I-cache and D-cache block refills (plus dirty-victim writeback)
// onto a single word-wide next-level memory port.
module l1_miss_arbiter #(
    parameter int ADDR_W    = l1_cache_pkg::ADDR_W,
    parameter int DATA_W    = l1_cache_pkg::DATA_W,
    parameter int BLK_WORDS = l1_cache_pkg::BLK_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    l1_miss_arbiter_if.master bus
);
    import l1_cache_pkg::*;

    localparam int IDX_W = $clog2(BLK_WORDS);
    localparam int BLK_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              owner_q;       // 1 = D owns the current transaction
    logic [BLK_W-1:0]  fill_addr_q;
    logic [BLK_W-1:0]  victim_q;
    logic              grant_d;
    logic              any_miss;
    logic              last_word;
    logic [DATA_W-1:0] wb_word;

    assign any_miss  = bus.i_miss | bus.d_miss;
    assign last_word = (idx_q == LAST_IDX);
    assign wb_word   = bus.d_wb_data;

    l1_rr_arbiter u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (bus.i_miss),
        .req_d    (bus.d_miss),
        .update   (state_q == ST_DONE),
        .served_d (owner_q),
        .grant_d  (grant_d)
    );

    // State, word counter and the addresses latched at grant time.
    // The victim's dirty bit is consumed at grant by the IDLE->WB/FILL choice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            owner_q     <= 1'b0;
            fill_addr_q <= '0;
            victim_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_miss) begin
                        idx_q       <= '0;
                        owner_q     <= grant_d;
                        fill_addr_q <= grant_d ? bus.d_addr : bus.i_addr;
                        victim_q    <= bus.d_victim_addr;
                    end
                end
                ST_WB, ST_FILL: begin
                    // Counter wraps to 0 after the last word, ready for FILL.
                    if (bus.mem_ack) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and all outputs; memory request is a pure function
    // of state so addr/we/wdata stay stable while waiting for mem_ack.
    always_comb begin
        state_d          = state_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.d_wb_idx     = '0;
        bus.i_fill_valid = 1'b0;
        bus.i_fill_idx   = '0;
        bus.i_fill_data  = '0;
        bus.i_done       = 1'b0;
        bus.d_fill_valid = 1'b0;
        bus.d_fill_idx   = '0;
        bus.d_fill_data  = '0;
        bus.d_done       = 1'b0;
        bus.busy         = (state_q != ST_IDLE);
        bus.owner_d      = (state_q != ST_IDLE) & owner_q;

        case (state_q)
            ST_IDLE: begin
                if (any_miss) state_d = (grant_d && bus.d_dirty) ? ST_WB : ST_FILL;
            end
            ST_WB: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {victim_q, idx_q};
                bus.mem_wdata = wb_word;
                bus.d_wb_idx  = idx_q;
                if (bus.mem_ack && last_word) state_d = ST_FILL;
            end
            ST_FILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {fill_addr_q, idx_q};
                if (bus.mem_ack) begin
                    if (owner_q) begin
                        bus.d_fill_valid = 1'b1;
                        bus.d_fill_idx   = idx_q;
                        bus.d_fill_data  = bus.mem_rdata;
                    end else begin
                        bus.i_fill_valid = 1'b1;
                        bus.i_fill_idx   = idx_q;
                        bus.i_fill_data  = bus.mem_rdata;
                    end
                    if (last_word) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (owner_q) bus.d_done = 1'b1;
                else         bus.i_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
